// File: rtl/multi_channel_arbiter.sv
// Multi-channel sensor arbiter: per-channel FIFOs, fixed-priority-with-aging or
// round-robin selection, and one registered valid/ready output stage.
module multi_channel_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int AGE_LIMIT  = 8,
  parameter int ID_W       = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     mode,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  input  logic [NUM_CH-1:0]        ch_valid,
  output logic [NUM_CH-1:0]        ch_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [ID_W-1:0]          out_id,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH-1:0]        pending,
  output logic [NUM_CH-1:0]        overflow,
  input  logic                     clear_overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem    [NUM_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr [NUM_CH];
  logic [CNT_W-1:0]  count  [NUM_CH];
  logic [7:0]        age    [NUM_CH];
  logic [ID_W-1:0]   last_grant;

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic [NUM_CH-1:0] aged;
  logic              slot_free;
  logic              grant_valid;
  logic [ID_W-1:0]   grant_idx;
  logic [DATA_W-1:0] head_data;
  int                rr_idx;

  always_comb begin
    ch_ready = '0;
    pending  = '0;
    push     = '0;
    aged     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pending[i]  = (count[i] != '0);
      ch_ready[i] = (count[i] != CNT_W'(FIFO_DEPTH)) && !rst;
      push[i]     = ch_valid[i] && ch_ready[i];
      aged[i]     = pending[i] && (age[i] >= 8'(AGE_LIMIT));
    end
  end

  // Loops run from lowest to highest priority so the last match wins.
  always_comb begin
    slot_free   = !out_valid || out_ready;
    grant_valid = slot_free && enable && (|pending);
    grant_idx   = '0;
    rr_idx      = 0;
    if (!mode) begin
      for (int i = NUM_CH - 1; i >= 0; i--)
        if (pending[i]) grant_idx = ID_W'(i);
      if (|aged)
        for (int i = NUM_CH - 1; i >= 0; i--)
          if (aged[i]) grant_idx = ID_W'(i);
    end else begin
      for (int k = NUM_CH; k >= 1; k--) begin
        rr_idx = (int'(last_grant) + k) % NUM_CH;
        if (pending[rr_idx]) grant_idx = ID_W'(rr_idx);
      end
    end
    pop = '0;
    for (int i = 0; i < NUM_CH; i++)
      pop[i] = grant_valid && (grant_idx == ID_W'(i));
  end

  assign head_data = mem[grant_idx][rd_ptr[grant_idx]];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++)
      if (push[i]) mem[i][wr_ptr[i]] <= ch_data[i*DATA_W +: DATA_W];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
        age[i]    <= '0;
      end
      overflow <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
        case ({push[i], pop[i]})
          2'b10:   count[i] <= count[i] + CNT_W'(1);
          2'b01:   count[i] <= count[i] - CNT_W'(1);
          default: ;
        endcase
        if (ch_valid[i] && !ch_ready[i])
          overflow[i] <= 1'b1;
        else if (clear_overflow)
          overflow[i] <= 1'b0;
        // Ages only move on grant cycles, so they freeze while enable is low.
        if (!pending[i] || pop[i])
          age[i] <= '0;
        else if (grant_valid && age[i] != 8'hFF)
          age[i] <= age[i] + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_id     <= '0;
      last_grant <= ID_W'(NUM_CH - 1);
    end else if (slot_free) begin
      if (grant_valid) begin
        out_valid  <= 1'b1;
        out_data   <= head_data;
        out_id     <= grant_idx;
        last_grant <= grant_idx;
      end else begin
        out_valid  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_multi_channel_arbiter.sv
// Testbench for multi_channel_arbiter: directed scenarios plus randomized traffic
// checked against a queue-based reference model.
module tb_multi_channel_arbiter;
  localparam int NUM_CH = 4;
  localparam int DATA_W = 16;
  localparam int FIFO_DEPTH = 4;
  localparam int ID_W = 2;
  localparam int M_AGE_LIMIT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b0;
  logic mode = 1'b0;
  logic out_ready = 1'b0;
  logic clear_overflow = 1'b0;
  logic [NUM_CH*DATA_W-1:0] ch_data = '0;
  logic [NUM_CH-1:0] ch_valid = '0;

  logic [NUM_CH-1:0] ch_ready, pending, overflow;
  logic [DATA_W-1:0] out_data;
  logic [ID_W-1:0]   out_id;
  logic              out_valid;
  logic [NUM_CH-1:0] a_ch_ready, a_pending, a_overflow;
  logic [DATA_W-1:0] a_out_data;
  logic [ID_W-1:0]   a_out_id;
  logic              a_out_valid;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multi_channel_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .AGE_LIMIT(M_AGE_LIMIT)) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .ch_data(ch_data), .ch_valid(ch_valid),
    .ch_ready(ch_ready), .out_data(out_data), .out_id(out_id), .out_valid(out_valid),
    .out_ready(out_ready), .pending(pending), .overflow(overflow), .clear_overflow(clear_overflow));

  multi_channel_arbiter #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .AGE_LIMIT(2)) dut_age (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .ch_data(ch_data), .ch_valid(ch_valid),
    .ch_ready(a_ch_ready), .out_data(a_out_data), .out_id(a_out_id), .out_valid(a_out_valid),
    .out_ready(out_ready), .pending(a_pending), .overflow(a_overflow), .clear_overflow(clear_overflow));

  // Reference model of the AGE_LIMIT=8 instance: one queue per channel.
  typedef logic [DATA_W-1:0] word_t;
  word_t mq [NUM_CH][$];
  int m_age [NUM_CH];
  int m_last, m_id, m_g;
  logic m_valid, m_free;
  word_t m_data;
  logic [NUM_CH-1:0] m_ovf, m_full, m_pend;

  function automatic int m_pick();
    int aged_ch = -1;
    int pend_ch = -1;
    if (mode) begin
      for (int k = 1; k <= NUM_CH; k++)
        if (mq[(m_last + k) % NUM_CH].size() != 0) return (m_last + k) % NUM_CH;
      return -1;
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (mq[i].size() != 0) begin
        if (pend_ch < 0) pend_ch = i;
        if (aged_ch < 0 && m_age[i] >= M_AGE_LIMIT) aged_ch = i;
      end
    end
    return (aged_ch >= 0) ? aged_ch : pend_ch;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        mq[i].delete();
        m_age[i] = 0;
      end
      m_last = NUM_CH - 1; m_valid = 1'b0; m_data = '0; m_id = 0; m_ovf = '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        m_pend[i] = (mq[i].size() != 0);
        m_full[i] = (mq[i].size() >= FIFO_DEPTH);
      end
      m_free = !m_valid || out_ready;
      m_g = (m_free && enable) ? m_pick() : -1;
      if (m_free) begin
        if (m_g >= 0) begin
          m_valid = 1'b1; m_data = mq[m_g].pop_front(); m_id = m_g; m_last = m_g;
        end else begin
          m_valid = 1'b0;
        end
      end
      for (int i = 0; i < NUM_CH; i++) begin
        if (m_g >= 0) m_age[i] = (i == m_g || !m_pend[i]) ? 0 : ((m_age[i] < 255) ? m_age[i] + 1 : 255);
        else if (!m_pend[i]) m_age[i] = 0;
        if (ch_valid[i] && !m_full[i]) mq[i].push_back(ch_data[i*DATA_W +: DATA_W]);
        if (ch_valid[i] && m_full[i]) m_ovf[i] = 1'b1;
        else if (clear_overflow) m_ovf[i] = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; enable = 1'b0; mode = 1'b0; out_ready = 1'b0;
    clear_overflow = 1'b0; ch_valid = '0; ch_data = '0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic preload(input logic [NUM_CH-1:0] mask, input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      ch_valid = mask;
      for (int c = 0; c < NUM_CH; c++) ch_data[c*DATA_W +: DATA_W] = 16'(c*256 + k);
    end
    @(negedge clk);
    ch_valid = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({ch_ready, pending, overflow, out_valid} !== '0) begin
      miscompares++; $display("FAIL reset_flags got %b want 0", {ch_ready, pending, overflow, out_valid});
    end
    vectors++;
    if ({out_data, out_id} !== '0) begin
      miscompares++; $display("FAIL reset_data got %h want 0", {out_data, out_id});
    end
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (ch_ready !== 4'hF) begin miscompares++; $display("FAIL reset_ready got %b want 1111", ch_ready); end
  endtask

  task automatic test_single();
    do_reset();
    out_ready = 1'b1; enable = 1'b1;
    ch_valid = 4'b0100; ch_data[2*DATA_W +: DATA_W] = 16'hA000;
    @(negedge clk);
    ch_valid = '0;
    vectors++;
    if (pending !== 4'b0100 || out_valid !== 1'b0) begin
      miscompares++; $display("FAIL single_nobypass got pend=%b v=%b want 0100/0", pending, out_valid);
    end
    @(negedge clk);
    vectors++;
    if ({out_valid, out_id, out_data, pending} !== {1'b1, 2'd2, 16'hA000, 4'b0000}) begin
      miscompares++; $display("FAIL single_out got v=%b id=%0d d=%h p=%b want 1/2/a000/0000", out_valid, out_id, out_data, pending);
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL single_drain got %b want 0", out_valid); end
  endtask

  task automatic test_fixed_order();
    int exp_ch;
    do_reset();
    preload(4'b1111, 2);
    enable = 1'b1; out_ready = 1'b1;
    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      exp_ch = g / 2;
      vectors++;
      if ({out_valid, out_id, out_data} !== {1'b1, ID_W'(exp_ch), 16'(exp_ch*256 + g%2)}) begin
        miscompares++; $display("FAIL fixed_order[%0d] got v=%b id=%0d d=%h want id=%0d d=%h", g, out_valid, out_id, out_data, exp_ch, exp_ch*256 + g%2);
      end
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL fixed_idle got %b want 0", out_valid); end
  endtask

  task automatic test_aging();
    logic [ID_W-1:0] exp_id [4];
    logic [DATA_W-1:0] exp_d [4];
    exp_id = '{2'd0, 2'd0, 2'd3, 2'd0};
    exp_d  = '{16'h0000, 16'h0001, 16'h3000, 16'h0002};
    do_reset();
    out_ready = 1'b1;
    ch_valid = 4'b1001;
    ch_data[0 +: DATA_W] = 16'h0000; ch_data[3*DATA_W +: DATA_W] = 16'h3000;
    @(negedge clk);
    enable = 1'b1; ch_valid = 4'b0001; ch_data[0 +: DATA_W] = 16'h0001;
    for (int g = 0; g < 4; g++) begin
      @(negedge clk);
      vectors++;
      if ({a_out_valid, a_out_id, a_out_data} !== {1'b1, exp_id[g], exp_d[g]}) begin
        miscompares++; $display("FAIL aging_grant[%0d] got v=%b id=%0d d=%h want id=%0d d=%h", g, a_out_valid, a_out_id, a_out_data, exp_id[g], exp_d[g]);
      end
      if (g == 1) begin
        vectors++;
        if (dut_age.age[3] !== 8'd2) begin miscompares++; $display("FAIL aging_age_before got %0d want 2", dut_age.age[3]); end
      end
      if (g == 2) begin
        vectors++;
        if (dut_age.age[3] !== 8'd0) begin miscompares++; $display("FAIL aging_age_cleared got %0d want 0", dut_age.age[3]); end
        vectors++;
        if (out_id !== 2'd0) begin miscompares++; $display("FAIL aging_limit8 got id %0d want 0", out_id); end
      end
      ch_data[0 +: DATA_W] = 16'(16'h0002 + g);
    end
    ch_valid = '0;
  endtask

  task automatic test_round_robin();
    do_reset();
    mode = 1'b1;
    preload(4'b1111, 3);
    enable = 1'b1; out_ready = 1'b1;
    for (int g = 0; g < 12; g++) begin
      @(negedge clk);
      vectors++;
      if ({out_valid, out_id, out_data} !== {1'b1, ID_W'(g % 4), 16'((g % 4)*256 + g/4)}) begin
        miscompares++; $display("FAIL rr_order[%0d] got v=%b id=%0d d=%h want id=%0d d=%h", g, out_valid, out_id, out_data, g % 4, (g % 4)*256 + g/4);
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      ch_valid = 4'b0010; ch_data[DATA_W +: DATA_W] = 16'(16'h1100 + k);
    end
    @(negedge clk);
    vectors++;
    if (ch_ready[1] !== 1'b0 || overflow !== 4'b0000) begin
      miscompares++; $display("FAIL ovf_full got rdy=%b ovf=%b want 0/0000", ch_ready[1], overflow);
    end
    ch_data[DATA_W +: DATA_W] = 16'hDEAD;
    @(negedge clk);
    ch_valid = '0;
    vectors++;
    if (overflow !== 4'b0010) begin miscompares++; $display("FAIL ovf_set got %b want 0010", overflow); end
    repeat (3) @(negedge clk);
    vectors++;
    if (overflow !== 4'b0010) begin miscompares++; $display("FAIL ovf_sticky got %b want 0010", overflow); end
    clear_overflow = 1'b1; ch_valid = 4'b0010;
    @(negedge clk);
    ch_valid = '0;
    vectors++;
    if (overflow !== 4'b0010) begin miscompares++; $display("FAIL ovf_set_wins got %b want 0010", overflow); end
    @(negedge clk);
    clear_overflow = 1'b0;
    vectors++;
    if (overflow !== 4'b0000) begin miscompares++; $display("FAIL ovf_clear got %b want 0000", overflow); end
    enable = 1'b1; out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      vectors++;
      if ({out_valid, out_id, out_data} !== {1'b1, 2'd1, 16'(16'h1100 + k)}) begin
        miscompares++; $display("FAIL ovf_drain[%0d] got v=%b id=%0d d=%h want 1/1/%h", k, out_valid, out_id, out_data, 16'h1100 + k);
      end
    end
    @(negedge clk);
    vectors++;
    if (out_valid !== 1'b0) begin miscompares++; $display("FAIL ovf_drain_end got %b want 0", out_valid); end
  endtask

  task automatic test_stall_reset();
    do_reset();
    preload(4'b0100, 2);
    enable = 1'b1; out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      vectors++;
      if ({out_valid, out_id, out_data} !== {1'b1, 2'd2, 16'h0200}) begin
        miscompares++; $display("FAIL stall_hold[%0d] got v=%b id=%0d d=%h want 1/2/0200", c, out_valid, out_id, out_data);
      end
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (out_valid !== 1'b0 || pending !== 4'b0000) begin
      miscompares++; $display("FAIL stall_async_rst got v=%b p=%b want 0/0000", out_valid, pending);
    end
    @(negedge clk);
    rst = 1'b0; enable = 1'b0;
  endtask

  task automatic test_random();
    logic [NUM_CH-1:0] exp_pend, exp_rdy;
    do_reset();
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      for (int i = 0; i < NUM_CH; i++) begin
        exp_pend[i] = (mq[i].size() != 0);
        exp_rdy[i]  = (mq[i].size() < FIFO_DEPTH);
      end
      vectors++;
      if (out_valid !== m_valid) begin
        miscompares++; $display("FAIL rand_valid cyc=%0d got %b want %b", cyc, out_valid, m_valid);
      end
      if (m_valid) begin
        vectors++;
        if ({out_id, out_data} !== {ID_W'(m_id), m_data}) begin
          miscompares++; $display("FAIL rand_word cyc=%0d got id=%0d d=%h want id=%0d d=%h", cyc, out_id, out_data, m_id, m_data);
        end
      end
      vectors++;
      if ({pending, ch_ready, overflow} !== {exp_pend, exp_rdy, m_ovf}) begin
        miscompares++; $display("FAIL rand_flags cyc=%0d got p=%b r=%b o=%b want p=%b r=%b o=%b", cyc, pending, ch_ready, overflow, exp_pend, exp_rdy, m_ovf);
      end
      for (int i = 0; i < NUM_CH; i++) begin
        ch_valid[i] = ($urandom_range(0, 99) < 40);
        ch_data[i*DATA_W +: DATA_W] = 16'($urandom);
      end
      out_ready = ($urandom_range(0, 99) < 65);
      enable = ($urandom_range(0, 99) < 90);
      clear_overflow = ($urandom_range(0, 99) < 5);
      if ($urandom_range(0, 99) < 8) mode = ~mode;
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fixed_order();
    test_aging();
    test_round_robin();
    test_overflow();
    test_stall_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
